// File: rtl/instr_decode_stage_if.sv
// Bus between fetch, the decode-stage register and the control-word lookup.
// The "master" side drives the fetched instruction and pipeline controls; the "slave" side is the decode stage.
interface instr_decode_stage_if #(
    parameter int PC_WIDTH  = 32,
    parameter int CNT_WIDTH = 8
);
    logic [31:0]          instr_in;
    logic [PC_WIDTH-1:0]  pc_in;
    logic                 in_valid;
    logic                 stall;
    logic                 flush;
    logic [5:0]           dec_instr_code;
    logic [31:0]          instr_out;
    logic [PC_WIDTH-1:0]  pc_out;
    logic                 out_valid;
    logic                 illegal;
    logic [CNT_WIDTH-1:0] illegal_count;

    modport master (
        output instr_in, pc_in, in_valid, stall, flush,
        input  dec_instr_code, instr_out, pc_out, out_valid, illegal, illegal_count
    );

    modport slave (
        input  instr_in, pc_in, in_valid, stall, flush,
        output dec_instr_code, instr_out, pc_out, out_valid, illegal, illegal_count
    );
endinterface

// File: rtl/instr_decode_stage.sv
// RV32I decode-stage register: classifies the fetched word into a 6-bit code and
// registers it with instruction and PC; supports stall, flush, bubbles and illegal counting.
module instr_decode_stage #(
    parameter int          PC_WIDTH  = 32,
    parameter int          CNT_WIDTH = 8,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic                    clk,
    input  logic                    rst,
    instr_decode_stage_if.slave     bus
);
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [5:0] CODE_BUBBLE  = 6'd0;
    localparam logic [5:0] CODE_ILLEGAL = 6'd63;

    // Every opcode in the map ends in 2'b11, so instr[1:0]!=11 falls through to ILLEGAL.
    function automatic logic [5:0] decode_instr(input logic [31:0] ins);
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [5:0] c;
        op = ins[6:0];
        f3 = ins[14:12];
        f7 = ins[31:25];
        c  = CODE_ILLEGAL;
        case (op)
            OP_REG: begin
                if (f7 == F7_BASE) begin
                    case (f3)
                        3'd0: c = 6'd1;
                        3'd1: c = 6'd3;
                        3'd2: c = 6'd4;
                        3'd3: c = 6'd5;
                        3'd4: c = 6'd6;
                        3'd5: c = 6'd7;
                        3'd6: c = 6'd9;
                        default: c = 6'd10;
                    endcase
                end else if (f7 == F7_ALT) begin
                    if (f3 == 3'd0)      c = 6'd2;
                    else if (f3 == 3'd5) c = 6'd8;
                end
            end
            OP_IMM: begin
                case (f3)
                    3'd0: c = 6'd11;
                    3'd2: c = 6'd12;
                    3'd3: c = 6'd13;
                    3'd4: c = 6'd14;
                    3'd6: c = 6'd15;
                    3'd7: c = 6'd16;
                    3'd1: if (f7 == F7_BASE) c = 6'd17;
                    default: begin
                        if (f7 == F7_BASE)     c = 6'd18;
                        else if (f7 == F7_ALT) c = 6'd19;
                    end
                endcase
            end
            OP_LOAD: begin
                case (f3)
                    3'd0: c = 6'd20;
                    3'd1: c = 6'd21;
                    3'd2: c = 6'd22;
                    3'd4: c = 6'd23;
                    3'd5: c = 6'd24;
                    default: c = CODE_ILLEGAL;
                endcase
            end
            OP_STORE: begin
                case (f3)
                    3'd0: c = 6'd25;
                    3'd1: c = 6'd26;
                    3'd2: c = 6'd27;
                    default: c = CODE_ILLEGAL;
                endcase
            end
            OP_BRANCH: begin
                case (f3)
                    3'd0: c = 6'd28;
                    3'd1: c = 6'd29;
                    3'd4: c = 6'd30;
                    3'd5: c = 6'd31;
                    3'd6: c = 6'd32;
                    3'd7: c = 6'd33;
                    default: c = CODE_ILLEGAL;
                endcase
            end
            OP_JAL:    c = 6'd34;
            OP_JALR:   if (f3 == 3'd0) c = 6'd35;
            OP_LUI:    c = 6'd36;
            OP_AUIPC:  c = 6'd37;
            OP_SYSTEM: begin
                if (f3 == 3'd1)      c = 6'd38;
                else if (f3 == 3'd5) c = 6'd39;
            end
            default:   c = CODE_ILLEGAL;
        endcase
        return c;
    endfunction

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    logic [5:0]           code_p0;
    logic                 is_illegal_p0;
    logic [5:0]           code_p1;
    logic [31:0]          instr_p1;
    logic [PC_WIDTH-1:0]  pc_p1;
    logic                 vld_p1;
    logic                 illegal_p1;
    logic [CNT_WIDTH-1:0] cnt_p1;

    assign code_p0       = decode_instr(bus.instr_in);
    assign is_illegal_p0 = (code_p0 == CODE_ILLEGAL);

    // Stage p0 -> p1: decoded word registered for the control-word lookup
    always_ff @(posedge clk) begin
        if (rst) begin
            code_p1    <= CODE_BUBBLE;
            instr_p1   <= NOP_INSTR;
            pc_p1      <= '0;
            vld_p1     <= 1'b0;
            illegal_p1 <= 1'b0;
            cnt_p1     <= '0;
        end else if (bus.flush || (!bus.stall && !bus.in_valid)) begin
            code_p1    <= CODE_BUBBLE;
            instr_p1   <= NOP_INSTR;
            pc_p1      <= bus.pc_in;
            vld_p1     <= 1'b0;
            illegal_p1 <= 1'b0;
        end else if (!bus.stall) begin
            code_p1    <= code_p0;
            instr_p1   <= bus.instr_in;
            pc_p1      <= bus.pc_in;
            vld_p1     <= 1'b1;
            illegal_p1 <= is_illegal_p0;
            if (is_illegal_p0) begin
                cnt_p1 <= sat_inc(cnt_p1);
            end
        end
    end

    assign bus.dec_instr_code = code_p1;
    assign bus.instr_out      = instr_p1;
    assign bus.pc_out         = pc_p1;
    assign bus.out_valid      = vld_p1;
    assign bus.illegal        = illegal_p1;
    assign bus.illegal_count  = cnt_p1;
endmodule
